fb_sram_arbiter: RTL and testbench
==================================

# fb_sram_arbiter

Shares the single-port 16-bit frame-buffer SRAM between the VGA display fetch and one writer (CPU/sprite engine). Runs on the 50 MHz system clock and tracks the VGA controller's DrawX/DrawY through a one-cycle pixel tick. It prefetches each 2-pixel word one pixel pair ahead so display reads always take priority. The writer receives every SRAM cycle the display does not need.

## Interface

Parameters:
- FB_BASE, 20'h00000, SRAM word address of pixel (0,0)
- H_TOTAL, 800, pixels per line including blanking
- V_TOTAL, 525, lines per frame including blanking

Ports:
- Clk  in  1  50 MHz system clock; the only clock
- Reset  in  1  asynchronous, active-high; clears all state
- pix_tick  in  1  one-Clk pulse in the first Clk cycle a new DrawX/DrawY is presented
- DrawX, DrawY  in  10 each  current pixel coordinates; stable between ticks
- wr_req  in  1  writer request; held with wr_addr/wr_data until wr_ack
- wr_addr  in  20  SRAM word address for the write
- wr_data  in  16  write word
- wr_ack  out  1  request accepted this cycle; combinational from wr_req
- sram_addr  out  20  registered SRAM address
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  registered SRAM strobes, active low
- sram_wdata  out  16  registered write data
- sram_dq_oe  out  1  registered; top level drives DQ from sram_wdata when 1
- sram_rdata  in  16  SRAM DQ input
- pixel  out  8  registered pixel index for the current DrawX/DrawY

## Operation

- Memory layout: 2 pixels per word, low byte = even x. Word address = FB_BASE + y*320 + (x>>1), computed as (y<<8)+(y<<6)+(x>>1). Sums wrap mod 2^20.
- Fetch trigger: fires in a pix_tick cycle with DrawX[0]=0. Target:
  - DrawX<638 and DrawY<480: (DrawX+2, DrawY).
  - DrawX==H_TOTAL-2: (0, ny), where ny = (DrawY==V_TOTAL-1) ? 0 : DrawY+1. Fires only if ny<480.
  - Otherwise no trigger.
- States: IDLE, RD, WR. Next state is chosen every cycle:
  - trigger → RD with the target address.
  - else wr_req → WR; wr_ack=1 this cycle; wr_addr/wr_data captured.
  - else → IDLE.
- Reads win every collision. A writer blocked by a trigger is accepted next cycle, because triggers are at least 4 cycles apart.
- Strobes by state:
  - IDLE: ce_n=oe_n=we_n=1, dq_oe=0.
  - RD: ce_n=0, oe_n=0, we_n=1, dq_oe=0.
  - WR: ce_n=0, we_n=0, oe_n=1, dq_oe=1.
- sram_addr and sram_wdata keep their last values in IDLE.
- Back-to-back WR cycles are allowed. The writer may present its next request in the cycle after wr_ack.
- At the end of an RD cycle, sram_rdata is latched into next_word.
- Pixel update on every pix_tick:
  - Outside active area (DrawX≥640 or DrawY≥480): pixel←0.
  - Active, DrawX even: disp_word←next_word, pixel←next_word[7:0].
  - Active, DrawX odd: pixel←disp_word[15:8].

## Timing

- Reset values: pixel=0, sram_addr=0, sram_wdata=0, ce_n=oe_n=we_n=1, dq_oe=0, state IDLE, next_word=disp_word=0.
- wr_ack is forced to 0 while Reset=1.
- Reset mid-write: the write whose WR cycle has not begun is dropped, and wr_ack is not repeated. The writer must re-request.
- Read: trigger in cycle T → RD in T+1 → next_word valid from T+2. The word is consumed at the next even tick (T+4 at the earliest).
- Write: wr_ack in cycle N → WR strobes in cycle N+1 → IDLE or the next operation in N+2.
- Pixel latency: pixel is valid from the Clk edge after pix_tick until the edge after the next pix_tick (2 Clk cycles).
- Worst-case wr_ack latency: 1 cycle after wr_req rises.

## Test plan

- Reset: assert Reset mid-frame → all outputs at reset values immediately (asynchronous); wr_ack=0 with wr_req=1.
- Address: DrawY=1, DrawX=4, pix_tick → next cycle sram_addr=FB_BASE+323, oe_n=0, ce_n=0, we_n=1.
- Line/frame wrap: tick at DrawX=798:
  - DrawY=479 → no RD.
  - DrawY=524 → RD at sram_addr=FB_BASE+0.
  - DrawY=10 → RD at FB_BASE+3520.
- Collision: wr_req=1 (addr 0x00100, data 0xBEEF) in the same cycle as a trigger:
  - wr_ack=0 and RD in the next cycle.
  - wr_ack=1 in the cycle after the trigger.
  - Following cycle: WR with we_n=0, dq_oe=1, sram_wdata=0xBEEF.
- Pixel: RD returns 0xA55A for pair (6,2):
  - Tick at DrawX=6 → pixel=0x5A.
  - Tick at DrawX=7 → pixel=0xA5.
  - Tick at DrawX=640 → pixel=0.
- Write throughput: wr_req held continuously with fresh data each ack over a full line → exactly one RD per even active tick, and all other cycles WR with ack.

Source files
------------

// File: rtl/fb_sram_arbiter.sv
// Frame-buffer SRAM arbiter: display prefetch reads always win, one writer gets every other cycle.
// Each 16-bit word holds two pixels (low byte = even x); the next pair's word is read one pair ahead.
module fb_sram_arbiter #(
   parameter logic [19:0] FB_BASE = 20'h00000,
   parameter int          H_TOTAL = 800,
   parameter int          V_TOTAL = 525
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        pix_tick,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        wr_req,
   input  logic [19:0] wr_addr,
   input  logic [15:0] wr_data,
   output logic        wr_ack,
   output logic [19:0] sram_addr,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic [15:0] sram_wdata,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_rdata,
   output logic [7:0]  pixel
);

   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [19:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, dq_oe_q, dq_oe_d;
   logic [15:0] next_word_q, next_word_d;
   logic [7:0]  disp_hi_q, disp_hi_d;
   logic [7:0]  pixel_q, pixel_d;

   logic [9:0]  ny_s;
   logic [9:0]  trow_s;
   logic [8:0]  tcol_s;
   logic [19:0] row20_s;
   logic [19:0] taddr_s;
   logic        trigger_s;
   logic        active_s;

   // Prefetch trigger and target word address for the pixel pair after the current one
   always_comb begin
      ny_s      = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
      active_s  = (DrawX < 10'd640) && (DrawY < 10'd480);
      trigger_s = 1'b0;
      tcol_s    = DrawX[9:1] + 9'd1;
      trow_s    = DrawY;
      if (pix_tick && !DrawX[0]) begin
         if ((DrawX < 10'd638) && (DrawY < 10'd480)) begin
            trigger_s = 1'b1;
         end else if (DrawX == 10'(H_TOTAL - 2)) begin
            tcol_s    = 9'd0;
            trow_s    = ny_s;
            trigger_s = (ny_s < 10'd480);
         end else begin
            trigger_s = 1'b0;
         end
      end else begin
         trigger_s = 1'b0;
      end
      // y*320 as (y<<8)+(y<<6); the sum wraps at 20 bits
      row20_s = {10'd0, trow_s};
      taddr_s = FB_BASE + (row20_s << 8) + (row20_s << 6) + {11'd0, tcol_s};
      wr_ack  = wr_req && !trigger_s && !Reset;
   end

   // Next SRAM operation, its strobes, read-data capture and pixel selection
   always_comb begin
      state_d = IDLE;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (trigger_s) begin
         state_d = RD;
         addr_d  = taddr_s;
      end else if (wr_ack) begin
         state_d = WR;
         addr_d  = wr_addr;
         wdata_d = wr_data;
      end else begin
         state_d = IDLE;
      end

      case (state_d)
         RD: begin
            ce_n_d = 1'b0; oe_n_d = 1'b0; we_n_d = 1'b1; dq_oe_d = 1'b0;
         end
         WR: begin
            ce_n_d = 1'b0; oe_n_d = 1'b1; we_n_d = 1'b0; dq_oe_d = 1'b1;
         end
         default: begin
            ce_n_d = 1'b1; oe_n_d = 1'b1; we_n_d = 1'b1; dq_oe_d = 1'b0;
         end
      endcase

      if (state_q == RD) begin
         next_word_d = sram_rdata;
      end else begin
         next_word_d = next_word_q;
      end

      pixel_d   = pixel_q;
      disp_hi_d = disp_hi_q;
      if (pix_tick) begin
         if (!active_s) begin
            pixel_d = 8'h00;
         end else if (!DrawX[0]) begin
            disp_hi_d = next_word_q[15:8];
            pixel_d   = next_word_q[7:0];
         end else begin
            pixel_d = disp_hi_q;
         end
      end else begin
         pixel_d = pixel_q;
      end
   end

   // State and registered outputs
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         addr_q      <= 20'h00000;
         wdata_q     <= 16'h0000;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         dq_oe_q     <= 1'b0;
         next_word_q <= 16'h0000;
         disp_hi_q   <= 8'h00;
         pixel_q     <= 8'h00;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         dq_oe_q     <= dq_oe_d;
         next_word_q <= next_word_d;
         disp_hi_q   <= disp_hi_d;
         pixel_q     <= pixel_d;
      end
   end

   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;
   assign sram_ce_n  = ce_n_q;
   assign sram_oe_n  = oe_n_q;
   assign sram_we_n  = we_n_q;
   assign sram_dq_oe = dq_oe_q;
   assign pixel      = pixel_q;

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Bench for fb_sram_arbiter: directed vector table, hand sequences for collisions, pixels and reset,
// and random raster segments checked against a raster-level reference model.
module tb_fb_sram_arbiter;
   localparam logic [19:0] BASE = 20'h01000;
   localparam int HT = 800;
   localparam int VT = 525;
   localparam logic [3:0] S_IDLE = 4'b1110;
   localparam logic [3:0] S_RD   = 4'b0010;
   localparam logic [3:0] S_WR   = 4'b0101;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        pix_tick = 1'b0;
   logic [9:0]  DrawX = 10'd0;
   logic [9:0]  DrawY = 10'd0;
   logic        wr_req = 1'b1;
   logic [19:0] wr_addr = 20'h0;
   logic [15:0] wr_data = 16'h0;
   logic        wr_ack;
   logic [19:0] sram_addr;
   logic        sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe;
   logic [15:0] sram_wdata;
   logic [15:0] sram_rdata;
   logic [7:0]  pixel;
   logic [3:0]  strb;

   logic        rd_ovr_en = 1'b0;
   logic [15:0] rd_ovr_val = 16'h0;
   int          checks = 0;
   int          errors = 0;
   logic [19:0] exp_addr = 20'h0;
   logic [15:0] exp_wdata = 16'h0;
   logic [7:0]  exp_pix = 8'h0;
   int          seg_ticks = -1000;
   int          wr_mode = 0;
   int          rd_cnt = 0, wr_cnt = 0, idle_cnt = 0, ack_cnt = 0;

   fb_sram_arbiter #(.FB_BASE(BASE), .H_TOTAL(HT), .V_TOTAL(VT)) dut (
      .Clk(Clk), .Reset(Reset), .pix_tick(pix_tick), .DrawX(DrawX), .DrawY(DrawY),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .sram_wdata(sram_wdata), .sram_dq_oe(sram_dq_oe),
      .sram_rdata(sram_rdata), .pixel(pixel)
   );

   always #10 Clk = ~Clk;

   function automatic logic [15:0] pat(input logic [19:0] a);
      return a[15:0] ^ {4{a[19:16]}} ^ 16'h9E37;
   endfunction

   function automatic logic [19:0] word_addr(input int x, input int y);
      return 20'(int'(BASE) + y * 320 + x / 2);
   endfunction

   assign strb = {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe};
   assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? (rd_ovr_en ? rd_ovr_val : pat(sram_addr)) : 16'h0000;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pixel"}, 32'(pixel), 32'h0);
      chk({tag, "_addr"}, 32'(sram_addr), 32'h0);
      chk({tag, "_wdata"}, 32'(sram_wdata), 32'h0);
      chk({tag, "_strobes"}, 32'(strb), 32'(S_IDLE));
      chk({tag, "_ack"}, 32'(wr_ack), 32'h0);
   endtask

   // One Clk cycle: drive inputs, predict from raster rules, check after the edge
   task automatic run_cycle(input logic tick, input int x, input int y);
      logic fetch, ack_exp, ack_dut;
      int nx, ny;
      logic [3:0] exp_strb;
      logic [15:0] w;
      pix_tick = tick;
      DrawX = 10'(x);
      DrawY = 10'(y);
      #1;
      nx = x + 2;
      ny = y;
      if (nx >= HT) begin
         nx = 0;
         ny = (y + 1) % VT;
      end
      fetch = tick && (x % 2 == 0) && (nx < 640) && (ny < 480);
      ack_exp = wr_req && !fetch;
      ack_dut = wr_ack;
      chk("wr_ack", 32'(wr_ack), 32'(ack_exp));
      if (ack_dut) ack_cnt++;
      if (fetch) begin
         exp_strb = S_RD;
         exp_addr = word_addr(nx, ny);
      end else if (wr_req) begin
         exp_strb = S_WR;
         exp_addr = wr_addr;
         exp_wdata = wr_data;
      end else begin
         exp_strb = S_IDLE;
      end
      if (tick) begin
         seg_ticks++;
         if (x < 640 && y < 480) begin
            w = pat(word_addr(x, y));
            exp_pix = (x % 2 == 0) ? w[7:0] : w[15:8];
         end else begin
            exp_pix = 8'h00;
         end
      end
      @(posedge Clk);
      #1;
      if (strb == S_RD) rd_cnt++;
      else if (strb == S_WR) wr_cnt++;
      else if (strb == S_IDLE) idle_cnt++;
      chk("strobes", 32'(strb), 32'(exp_strb));
      chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
      chk("sram_wdata", 32'(sram_wdata), 32'(exp_wdata));
      if (seg_ticks >= 3) chk("pixel", 32'(pixel), 32'(exp_pix));
      pix_tick = 1'b0;
      if (wr_mode != 0) begin
         if (ack_dut) begin
            wr_addr = 20'h80000 | 20'($urandom_range(0, 32'h7FFFF));
            wr_data = 16'($urandom);
            wr_req = (wr_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
         end else if (!wr_req && $urandom_range(0, 3) == 0) begin
            wr_req = 1'b1;
            wr_addr = 20'h80000 | 20'($urandom_range(0, 32'h7FFFF));
            wr_data = 16'($urandom);
         end
      end
   endtask

   task automatic run_segment(input int x0, input int y0, input int nticks, input int gap_max);
      int x, y, gap;
      x = x0;
      y = y0;
      seg_ticks = 0;
      for (int t = 0; t < nticks; t++) begin
         gap = 3 + $urandom_range(0, gap_max);
         run_cycle(1'b1, x, y);
         for (int g = 0; g < gap; g++) run_cycle(1'b0, x, y);
         x++;
         if (x == HT) begin
            x = 0;
            y = (y + 1) % VT;
         end
      end
   endtask

   typedef struct {
      logic        tick;
      int          x;
      int          y;
      logic        req;
      logic        rd;
      logic [19:0] addr;
      logic        ack;
   } vec_t;

   vec_t vecs[13];

   initial begin
      vecs[0]  = '{1'b1, 4,   1,   1'b0, 1'b1, 20'h01143, 1'b0};
      vecs[1]  = '{1'b1, 798, 479, 1'b0, 1'b0, 20'h00000, 1'b0};
      vecs[2]  = '{1'b1, 798, 524, 1'b0, 1'b1, 20'h01000, 1'b0};
      vecs[3]  = '{1'b1, 798, 10,  1'b0, 1'b1, 20'h01DC0, 1'b0};
      vecs[4]  = '{1'b1, 636, 0,   1'b0, 1'b1, 20'h0113F, 1'b0};
      vecs[5]  = '{1'b1, 638, 0,   1'b1, 1'b0, 20'h00000, 1'b1};
      vecs[6]  = '{1'b1, 5,   1,   1'b0, 1'b0, 20'h00000, 1'b0};
      vecs[7]  = '{1'b0, 4,   1,   1'b0, 1'b0, 20'h00000, 1'b0};
      vecs[8]  = '{1'b1, 0,   479, 1'b0, 1'b1, 20'h266C1, 1'b0};
      vecs[9]  = '{1'b1, 0,   480, 1'b1, 1'b0, 20'h00000, 1'b1};
      vecs[10] = '{1'b1, 798, 478, 1'b0, 1'b1, 20'h266C0, 1'b0};
      vecs[11] = '{1'b1, 4,   1,   1'b1, 1'b1, 20'h01143, 1'b0};
      vecs[12] = '{1'b1, 2,   500, 1'b0, 1'b0, 20'h00000, 1'b0};

      // power-on reset with a pending writer request
      @(posedge Clk);
      @(posedge Clk);
      #1;
      chk_reset("por");
      Reset = 1'b0;
      wr_req = 1'b0;

      // directed vectors, each followed by one quiet cycle
      for (int i = 0; i < 13; i++) begin
         logic [3:0] es;
         pix_tick = vecs[i].tick;
         DrawX = 10'(vecs[i].x);
         DrawY = 10'(vecs[i].y);
         wr_req = vecs[i].req;
         wr_addr = 20'h90000 + 20'(i);
         wr_data = 16'h1000 + 16'(i);
         #1;
         chk($sformatf("vec%0d_ack", i), 32'(wr_ack), 32'(vecs[i].ack));
         @(posedge Clk);
         #1;
         if (vecs[i].rd) begin
            es = S_RD;
            exp_addr = vecs[i].addr;
         end else if (vecs[i].ack) begin
            es = S_WR;
            exp_addr = wr_addr;
            exp_wdata = wr_data;
         end else begin
            es = S_IDLE;
         end
         chk($sformatf("vec%0d_strobes", i), 32'(strb), 32'(es));
         chk($sformatf("vec%0d_addr", i), 32'(sram_addr), 32'(exp_addr));
         chk($sformatf("vec%0d_wdata", i), 32'(sram_wdata), 32'(exp_wdata));
         pix_tick = 1'b0;
         wr_req = 1'b0;
         @(posedge Clk);
         #1;
         chk($sformatf("vec%0d_quiet", i), 32'(strb), 32'(S_IDLE));
      end

      // write request colliding with a prefetch trigger
      wr_req = 1'b1;
      wr_addr = 20'h00100;
      wr_data = 16'hBEEF;
      pix_tick = 1'b1;
      DrawX = 10'd4;
      DrawY = 10'd1;
      #1;
      chk("coll_ack_blocked", 32'(wr_ack), 32'h0);
      @(posedge Clk);
      #1;
      chk("coll_rd_strobes", 32'(strb), 32'(S_RD));
      chk("coll_rd_addr", 32'(sram_addr), 32'h01143);
      pix_tick = 1'b0;
      #1;
      chk("coll_ack_next", 32'(wr_ack), 32'h1);
      @(posedge Clk);
      #1;
      wr_req = 1'b0;
      chk("coll_wr_strobes", 32'(strb), 32'(S_WR));
      chk("coll_wr_addr", 32'(sram_addr), 32'h00100);
      chk("coll_wr_data", 32'(sram_wdata), 32'hBEEF);
      exp_addr = 20'h00100;
      exp_wdata = 16'hBEEF;

      // pixel path: pair (6,2) reads back 0xA55A
      seg_ticks = -1000;
      rd_ovr_val = 16'hA55A;
      rd_ovr_en = 1'b1;
      run_cycle(1'b1, 4, 2);
      run_cycle(1'b0, 4, 2);
      run_cycle(1'b0, 4, 2);
      rd_ovr_en = 1'b0;
      run_cycle(1'b0, 4, 2);
      run_cycle(1'b1, 5, 2);
      for (int g = 0; g < 3; g++) run_cycle(1'b0, 5, 2);
      run_cycle(1'b1, 6, 2);
      chk("pix_even", 32'(pixel), 32'h5A);
      for (int g = 0; g < 3; g++) run_cycle(1'b0, 6, 2);
      chk("pix_even_hold", 32'(pixel), 32'h5A);
      run_cycle(1'b1, 7, 2);
      chk("pix_odd", 32'(pixel), 32'hA5);
      for (int g = 0; g < 3; g++) run_cycle(1'b0, 7, 2);
      run_cycle(1'b1, 640, 2);
      chk("pix_blank", 32'(pixel), 32'h0);
      for (int g = 0; g < 3; g++) run_cycle(1'b0, 640, 2);

      // random raster segments with a random writer
      wr_mode = 1;
      for (int s = 0; s < 10; s++) begin
         int xs, ys;
         case (s)
            0: begin xs = 760; ys = 479; end
            1: begin xs = 760; ys = 524; end
            2: begin xs = 700; ys = 478; end
            default: begin
               xs = 2 * $urandom_range(0, 399);
               ys = $urandom_range(0, 524);
            end
         endcase
         run_segment(xs, ys, 60, 2);
      end

      // full active line with the writer always requesting
      wr_mode = 2;
      wr_req = 1'b1;
      wr_addr = 20'h80000 | 20'($urandom_range(0, 32'h7FFFF));
      wr_data = 16'($urandom);
      rd_cnt = 0;
      wr_cnt = 0;
      idle_cnt = 0;
      ack_cnt = 0;
      run_segment(0, 5, 800, 0);
      chk("line_reads", 32'(rd_cnt), 32'd320);
      chk("line_writes", 32'(wr_cnt), 32'd2880);
      chk("line_acks", 32'(ack_cnt), 32'd2880);
      chk("line_idles", 32'(idle_cnt), 32'd0);

      // asynchronous reset in the middle of a frame
      wr_mode = 0;
      #4;
      wr_req = 1'b1;
      Reset = 1'b1;
      #1;
      chk_reset("midreset");
      @(posedge Clk);
      #1;
      chk_reset("midreset_held");
      Reset = 1'b0;
      exp_addr = 20'h0;
      exp_wdata = 16'h0;
      seg_ticks = -1000;
      wr_addr = 20'h9ABCD;
      wr_data = 16'h1234;
      run_cycle(1'b0, 100, 100);
      wr_req = 1'b0;
      run_cycle(1'b0, 100, 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
